// File: rtl/cheby_ram_arbiter.sv
// Two-requester arbiter for port A of a cheby_dpssram (1-cycle read latency, byte selects).
// Define CHEBY_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module cheby_ram_arbiter #(
    parameter int G_ADDR_WIDTH = 10,
    parameter int G_DATA_WIDTH = 8,
    parameter int G_SEL_WIDTH  = G_DATA_WIDTH / 8
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic                    r0_req_i,
    input  logic                    r0_we_i,
    input  logic [G_ADDR_WIDTH-1:0] r0_adr_i,
    input  logic [G_DATA_WIDTH-1:0] r0_dat_i,
    input  logic [G_SEL_WIDTH-1:0]  r0_sel_i,
    output logic                    r0_ack_o,
    output logic [G_DATA_WIDTH-1:0] r0_dat_o,
    input  logic                    r1_req_i,
    input  logic                    r1_we_i,
    input  logic [G_ADDR_WIDTH-1:0] r1_adr_i,
    input  logic [G_DATA_WIDTH-1:0] r1_dat_i,
    input  logic [G_SEL_WIDTH-1:0]  r1_sel_i,
    output logic                    r1_ack_o,
    output logic [G_DATA_WIDTH-1:0] r1_dat_o,
    output logic [G_ADDR_WIDTH-1:0] ram_adr_o,
    output logic [G_DATA_WIDTH-1:0] ram_dat_o,
    output logic [G_SEL_WIDTH-1:0]  ram_sel_o,
    output logic                    ram_wr_o,
    output logic                    ram_rd_o,
    input  logic [G_DATA_WIDTH-1:0] ram_dat_i,
    output logic                    busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RDW,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    gnt_q, gnt_d;
    logic                    win;
    logic                    win_we;
`ifdef CHEBY_ARB_RR_EN
    logic                    last_q, last_d;
`endif

    logic [G_ADDR_WIDTH-1:0] ram_adr_q, ram_adr_d;
    logic [G_DATA_WIDTH-1:0] ram_dat_q, ram_dat_d;
    logic [G_SEL_WIDTH-1:0]  ram_sel_q, ram_sel_d;
    logic                    ram_wr_q, ram_wr_d;
    logic                    ram_rd_q, ram_rd_d;
    logic                    ack0_q, ack0_d;
    logic                    ack1_q, ack1_d;
    logic [G_DATA_WIDTH-1:0] dat0_q, dat0_d;
    logic [G_DATA_WIDTH-1:0] dat1_q, dat1_d;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
`ifdef CHEBY_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
`ifdef CHEBY_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
`ifdef CHEBY_ARB_RR_EN
        last_d  = last_q;
        if (r0_req_i && r1_req_i) win = ~last_q;
        else                      win = r1_req_i;
`else
        win = ~r0_req_i & r1_req_i;
`endif
        win_we = win ? r1_we_i : r0_we_i;
        case (state_q)
            IDLE: begin
                if (r0_req_i || r1_req_i) begin
                    gnt_d   = win;
`ifdef CHEBY_ARB_RR_EN
                    last_d  = win;
`endif
                    state_d = win_we ? WR : RD;
                end
            end
            WR:      state_d = DONE;
            RD:      state_d = RDW;
            RDW:     state_d = DONE;
            // Requests are deliberately ignored here so a held req cannot be re-granted.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so strobes and acks leave flops.
    always_comb begin
        ram_adr_d = ram_adr_q;
        ram_dat_d = ram_dat_q;
        ram_sel_d = ram_sel_q;
        dat0_d    = dat0_q;
        dat1_d    = dat1_q;
        if (state_q == IDLE && state_d != IDLE) begin
            ram_adr_d = win ? r1_adr_i : r0_adr_i;
            ram_dat_d = win ? r1_dat_i : r0_dat_i;
            ram_sel_d = win ? r1_sel_i : r0_sel_i;
        end
        if (state_q == RDW) begin
            if (gnt_q) dat1_d = ram_dat_i;
            else       dat0_d = ram_dat_i;
        end
        ram_wr_d = (state_d == WR);
        ram_rd_d = (state_d == RD);
        ack0_d   = (state_d == DONE) && !gnt_d;
        ack1_d   = (state_d == DONE) && gnt_d;
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            ram_adr_q <= '0;
            ram_dat_q <= '0;
            ram_sel_q <= '0;
            ram_wr_q  <= 1'b0;
            ram_rd_q  <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            dat0_q    <= '0;
            dat1_q    <= '0;
        end else begin
            ram_adr_q <= ram_adr_d;
            ram_dat_q <= ram_dat_d;
            ram_sel_q <= ram_sel_d;
            ram_wr_q  <= ram_wr_d;
            ram_rd_q  <= ram_rd_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            dat0_q    <= dat0_d;
            dat1_q    <= dat1_d;
        end
    end

    assign ram_adr_o = ram_adr_q;
    assign ram_dat_o = ram_dat_q;
    assign ram_sel_o = ram_sel_q;
    assign ram_wr_o  = ram_wr_q;
    assign ram_rd_o  = ram_rd_q;
    assign r0_ack_o  = ack0_q;
    assign r1_ack_o  = ack1_q;
    assign r0_dat_o  = dat0_q;
    assign r1_dat_o  = dat1_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_cheby_ram_arbiter.sv
// Directed testbench for cheby_ram_arbiter with a 1-cycle-latency RAM model on port A.
// Contention expectations follow the CHEBY_ARB_RR_EN build setting.
module tb_cheby_ram_arbiter;

    logic       aclk = 1'b0;
    logic       areset_n = 1'b0;
    logic       r0_req = 1'b0, r0_we = 1'b0;
    logic [9:0] r0_adr = '0;
    logic [7:0] r0_dat = '0;
    logic [0:0] r0_sel = '0;
    logic       r0_ack;
    logic [7:0] r0_dat_o;
    logic       r1_req = 1'b0, r1_we = 1'b0;
    logic [9:0] r1_adr = '0;
    logic [7:0] r1_dat = '0;
    logic [0:0] r1_sel = '0;
    logic       r1_ack;
    logic [7:0] r1_dat_o;
    logic [9:0] ram_adr;
    logic [7:0] ram_dat;
    logic [0:0] ram_sel;
    logic       ram_wr, ram_rd;
    logic [7:0] ram_q = '0;
    logic       busy;
    logic [7:0] mem [0:1023];

    int passed = 0;
    int total  = 0;

    always #5 aclk = ~aclk;

    cheby_ram_arbiter #(.G_ADDR_WIDTH(10), .G_DATA_WIDTH(8), .G_SEL_WIDTH(1)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .r0_req_i(r0_req), .r0_we_i(r0_we), .r0_adr_i(r0_adr), .r0_dat_i(r0_dat),
        .r0_sel_i(r0_sel), .r0_ack_o(r0_ack), .r0_dat_o(r0_dat_o),
        .r1_req_i(r1_req), .r1_we_i(r1_we), .r1_adr_i(r1_adr), .r1_dat_i(r1_dat),
        .r1_sel_i(r1_sel), .r1_ack_o(r1_ack), .r1_dat_o(r1_dat_o),
        .ram_adr_o(ram_adr), .ram_dat_o(ram_dat), .ram_sel_o(ram_sel),
        .ram_wr_o(ram_wr), .ram_rd_o(ram_rd), .ram_dat_i(ram_q), .busy_o(busy)
    );

    // RAM model: byte-selected write, registered read one cycle after rd.
    always @(posedge aclk) begin
        if (ram_wr && ram_sel[0]) mem[ram_adr] <= ram_dat;
        if (ram_rd) ram_q <= mem[ram_adr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        #2;
        total++; if (ram_wr !== 1'b0) $display("FAIL rst_wr: got %b expected 0", ram_wr); else passed++;
        total++; if (ram_rd !== 1'b0) $display("FAIL rst_rd: got %b expected 0", ram_rd); else passed++;
        total++; if ({r0_ack, r1_ack} !== 2'b00) $display("FAIL rst_ack: got %b expected 00", {r0_ack, r1_ack}); else passed++;
        total++; if (ram_adr !== 10'h000) $display("FAIL rst_adr: got %h expected 000", ram_adr); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passed++;
        @(negedge aclk);
        areset_n = 1'b1;
    endtask

    task automatic test_single_write;
        @(posedge aclk); #1;
        r0_req = 1'b1; r0_we = 1'b1; r0_adr = 10'h005; r0_dat = 8'hA5; r0_sel = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        total++; if (ram_wr !== 1'b1) $display("FAIL sw_wr: got %b expected 1", ram_wr); else passed++;
        total++; if (ram_rd !== 1'b0) $display("FAIL sw_rd: got %b expected 0", ram_rd); else passed++;
        total++; if (ram_adr !== 10'h005) $display("FAIL sw_adr: got %h expected 005", ram_adr); else passed++;
        total++; if (ram_dat !== 8'hA5) $display("FAIL sw_dat: got %h expected a5", ram_dat); else passed++;
        total++; if (ram_sel !== 1'b1) $display("FAIL sw_sel: got %b expected 1", ram_sel); else passed++;
        total++; if (r0_ack !== 1'b0) $display("FAIL sw_ack_early: got %b expected 0", r0_ack); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL sw_busy: got %b expected 1", busy); else passed++;
        @(negedge aclk);
        total++; if (ram_wr !== 1'b0) $display("FAIL sw_wr_single: got %b expected 0", ram_wr); else passed++;
        total++; if (r0_ack !== 1'b1) $display("FAIL sw_ack0: got %b expected 1", r0_ack); else passed++;
        total++; if (r1_ack !== 1'b0) $display("FAIL sw_ack1: got %b expected 0", r1_ack); else passed++;
        r0_req = 1'b0;
        @(negedge aclk);
        total++; if (r0_ack !== 1'b0) $display("FAIL sw_ack_end: got %b expected 0", r0_ack); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL sw_idle: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_read_back;
        @(posedge aclk); #1;
        r1_req = 1'b1; r1_we = 1'b0; r1_adr = 10'h005; r1_dat = 8'h00; r1_sel = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        total++; if (ram_rd !== 1'b1) $display("FAIL rb_rd: got %b expected 1", ram_rd); else passed++;
        total++; if (ram_wr !== 1'b0) $display("FAIL rb_wr: got %b expected 0", ram_wr); else passed++;
        total++; if (ram_adr !== 10'h005) $display("FAIL rb_adr: got %h expected 005", ram_adr); else passed++;
        @(negedge aclk);
        total++; if (ram_rd !== 1'b0) $display("FAIL rb_rd_single: got %b expected 0", ram_rd); else passed++;
        total++; if (r1_ack !== 1'b0) $display("FAIL rb_ack_early: got %b expected 0", r1_ack); else passed++;
        @(negedge aclk);
        total++; if (r1_ack !== 1'b1) $display("FAIL rb_ack1: got %b expected 1", r1_ack); else passed++;
        total++; if (r1_dat_o !== 8'hA5) $display("FAIL rb_data: got %h expected a5", r1_dat_o); else passed++;
        total++; if (r0_ack !== 1'b0) $display("FAIL rb_ack0: got %b expected 0", r0_ack); else passed++;
        r1_req = 1'b0;
        @(negedge aclk);
        total++; if (r1_ack !== 1'b0) $display("FAIL rb_ack_end: got %b expected 0", r1_ack); else passed++;
        total++; if (r1_dat_o !== 8'hA5) $display("FAIL rb_hold: got %h expected a5", r1_dat_o); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rb_idle: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_sel_zero;
        @(posedge aclk); #1;
        r0_req = 1'b1; r0_we = 1'b1; r0_adr = 10'h005; r0_dat = 8'hFF; r0_sel = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        total++; if (ram_wr !== 1'b1) $display("FAIL sz_wr: got %b expected 1", ram_wr); else passed++;
        total++; if (ram_sel !== 1'b0) $display("FAIL sz_sel: got %b expected 0", ram_sel); else passed++;
        @(negedge aclk);
        total++; if (r0_ack !== 1'b1) $display("FAIL sz_ack: got %b expected 1", r0_ack); else passed++;
        r0_req = 1'b0;
        @(posedge aclk); #1;
        r0_req = 1'b1; r0_we = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        @(negedge aclk);
        @(negedge aclk);
        total++; if (r0_ack !== 1'b1) $display("FAIL sz_rd_ack: got %b expected 1", r0_ack); else passed++;
        total++; if (r0_dat_o !== 8'hA5) $display("FAIL sz_unchanged: got %h expected a5", r0_dat_o); else passed++;
        total++; if (r1_dat_o !== 8'hA5) $display("FAIL sz_r1_hold: got %h expected a5", r1_dat_o); else passed++;
        r0_req = 1'b0;
    endtask

    task automatic test_stale_req;
        int extra;
        extra = 0;
        @(posedge aclk); #1;
        r1_req = 1'b1; r1_we = 1'b1; r1_adr = 10'h007; r1_dat = 8'h3C; r1_sel = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        total++; if (ram_wr !== 1'b1) $display("FAIL st_wr: got %b expected 1", ram_wr); else passed++;
        @(negedge aclk);
        total++; if (r1_ack !== 1'b1) $display("FAIL st_ack: got %b expected 1", r1_ack); else passed++;
        @(posedge aclk); #1;
        r1_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            if (ram_wr || ram_rd || r0_ack || r1_ack) extra++;
        end
        total++; if (extra !== 0) $display("FAIL st_regrant: got %0d extra pulses expected 0", extra); else passed++;
    endtask

    task automatic test_withdraw;
        @(posedge aclk); #1;
        r1_req = 1'b1; r1_we = 1'b0; r1_adr = 10'h007; r1_sel = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        r1_req = 1'b0;
        total++; if (ram_rd !== 1'b1) $display("FAIL wd_rd: got %b expected 1", ram_rd); else passed++;
        @(negedge aclk);
        @(negedge aclk);
        total++; if (r1_ack !== 1'b1) $display("FAIL wd_ack: got %b expected 1", r1_ack); else passed++;
        total++; if (r1_dat_o !== 8'h3C) $display("FAIL wd_data: got %h expected 3c", r1_dat_o); else passed++;
        @(negedge aclk);
    endtask

    task automatic test_contention;
        int n_ack, both_ack, both_strobe;
        int ack_cyc [8];
        int ack_port [8];
        int exp_port [4];
`ifdef CHEBY_ARB_RR_EN
        exp_port = '{0, 1, 0, 1};
`else
        exp_port = '{0, 0, 0, 1};
`endif
        n_ack = 0; both_ack = 0; both_strobe = 0;
        @(posedge aclk); #1;
        areset_n = 1'b0;
        r0_req = 1'b1; r0_we = 1'b1; r0_adr = 10'h010; r0_dat = 8'h11; r0_sel = 1'b1;
        r1_req = 1'b1; r1_we = 1'b1; r1_adr = 10'h020; r1_dat = 8'h22; r1_sel = 1'b1;
        @(negedge aclk);
        areset_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge aclk);
            if (r0_ack && r1_ack) both_ack++;
            if (ram_wr && ram_rd) both_strobe++;
            if ((r0_ack || r1_ack) && n_ack < 8) begin
                ack_cyc[n_ack] = c;
                ack_port[n_ack] = r1_ack ? 1 : 0;
                n_ack++;
            end
`ifndef CHEBY_ARB_RR_EN
            if (c == 8) r0_req = 1'b0;
`endif
            if (c == 11) begin
                r0_req = 1'b0;
                r1_req = 1'b0;
            end
        end
        total++; if (n_ack !== 4) $display("FAIL ct_count: got %0d acks expected 4", n_ack); else passed++;
        total++; if (both_ack !== 0) $display("FAIL ct_coincident: got %0d expected 0", both_ack); else passed++;
        total++; if (both_strobe !== 0) $display("FAIL ct_strobes: got %0d expected 0", both_strobe); else passed++;
        for (int i = 0; i < 4; i++) begin
            if (i < n_ack) begin
                total++; if (ack_port[i] !== exp_port[i]) $display("FAIL ct_port%0d: got %0d expected %0d", i, ack_port[i], exp_port[i]); else passed++;
                total++; if (ack_cyc[i] !== 2 + 3 * i) $display("FAIL ct_cycle%0d: got %0d expected %0d", i, ack_cyc[i], 2 + 3 * i); else passed++;
            end
        end
        @(negedge aclk);
    endtask

    task automatic test_reset_mid_read;
        @(posedge aclk); #1;
        r0_req = 1'b1; r0_we = 1'b0; r0_adr = 10'h007; r0_sel = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        total++; if (ram_rd !== 1'b1) $display("FAIL rm_rd: got %b expected 1", ram_rd); else passed++;
        areset_n = 1'b0;
        r0_req = 1'b0;
        #1;
        total++; if (ram_rd !== 1'b0) $display("FAIL rm_rd_clr: got %b expected 0", ram_rd); else passed++;
        total++; if (ram_adr !== 10'h000) $display("FAIL rm_adr_clr: got %h expected 000", ram_adr); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b expected 0", busy); else passed++;
        total++; if (r1_dat_o !== 8'h00) $display("FAIL rm_dat1_clr: got %h expected 00", r1_dat_o); else passed++;
        total++; if (r0_dat_o !== 8'h00) $display("FAIL rm_dat0_clr: got %h expected 00", r0_dat_o); else passed++;
        @(negedge aclk);
        @(negedge aclk);
        total++; if ({r0_ack, r1_ack} !== 2'b00) $display("FAIL rm_no_ack: got %b expected 00", {r0_ack, r1_ack}); else passed++;
        areset_n = 1'b1;
        @(posedge aclk); #1;
        r0_req = 1'b1; r0_we = 1'b1; r0_adr = 10'h009; r0_dat = 8'h5A; r0_sel = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        total++; if (ram_wr !== 1'b1) $display("FAIL rm_wr: got %b expected 1", ram_wr); else passed++;
        total++; if (ram_adr !== 10'h009) $display("FAIL rm_wr_adr: got %h expected 009", ram_adr); else passed++;
        @(negedge aclk);
        total++; if (r0_ack !== 1'b1) $display("FAIL rm_wr_ack: got %b expected 1", r0_ack); else passed++;
        r0_req = 1'b0;
        @(negedge aclk);
        total++; if (busy !== 1'b0) $display("FAIL rm_idle: got %b expected 0", busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_back();
        test_sel_zero();
        test_stale_req();
        test_withdraw();
        test_contention();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cheby_ram_arbiter.md
# cheby_ram_arbiter

Two-requester arbiter that shares port A of a `cheby_dpssram` instance (byte-write-select enabled, 1-cycle read latency) between the bus-side register decoder and a second local master, such as a DMA or scrubber. Each requester issues a held request and gets back a single-cycle ack. The arbiter serialises accesses, drives the RAM strobes from registers and returns read data with the ack. It sits between the decoder's read/write request processes and the RAM instance, replacing the fixed write-over-read priority wiring.

## Interface
- `G_ADDR_WIDTH`, 10, RAM word-address width
- `G_DATA_WIDTH`, 8, RAM data width; must be a multiple of 8
- `G_SEL_WIDTH`, `G_DATA_WIDTH/8`, byte-select width

Ports:
- `aclk`  in  1  clock; everything is synchronous to its rising edge
- `areset_n`  in  1  reset, asynchronous, active-low
- `rN_req_i` (N=0,1)  in  1  request, level; held until ack
- `rN_we_i`  in  1  1 = write, 0 = read
- `rN_adr_i`  in  `G_ADDR_WIDTH`  word address
- `rN_dat_i`  in  `G_DATA_WIDTH`  write data
- `rN_sel_i`  in  `G_SEL_WIDTH`  byte enables, writes only
- `rN_ack_o`  out  1  one-cycle completion pulse
- `rN_dat_o`  out  `G_DATA_WIDTH`  read data, valid when `rN_ack_o`=1 for a read
- `ram_adr_o`  out  `G_ADDR_WIDTH`  to `addr_a_i`
- `ram_dat_o`  out  `G_DATA_WIDTH`  to `data_a_i`
- `ram_sel_o`  out  `G_SEL_WIDTH`  to `bwsel_a_i`
- `ram_wr_o`  out  1  to `wr_a_i`
- `ram_rd_o`  out  1  to `rd_a_i`
- `ram_dat_i`  in  `G_DATA_WIDTH`  from `data_a_o`
- `busy_o`  out  1  high whenever the state is not IDLE

## Operation
- Requester contract:
  - Address, data, sel and we are stable while req=1.
  - Req is deasserted no later than the cycle after ack.
- States: IDLE, WR, RD, RDW, DONE.
- IDLE, no req pending: stay in IDLE.
- IDLE, at least one req=1:
  - Select the winner and latch its index into `gnt`.
  - Register the winner's adr/dat/sel onto the `ram_*` outputs.
  - Go to WR if we=1, otherwise to RD.
- WR: `ram_wr_o`=1 with `ram_sel_o`=the latched sel, for exactly one cycle. Next state DONE; the ack is asserted in DONE.
- RD: `ram_rd_o`=1 for exactly one cycle. Next state RDW.
- RDW: capture `ram_dat_i` into `rN_dat_o[gnt]`. Next state DONE.
- DONE:
  - `rN_ack_o[gnt]`=1 for one cycle. Next state IDLE.
  - Requests are not sampled in DONE, so a stale req is never re-granted.
- Strobe exclusivity: `ram_wr_o` and `ram_rd_o` are never 1 together, and at most one ack is 1 per cycle.
- Read data hold: `rN_dat_o` keeps its value until that port's next read completes.
- Sel of zero on a write: still a full transaction. `ram_wr_o` pulses with sel=0, the RAM contents are unchanged, and the ack is still issued.
- Req withdrawn mid-transaction (protocol violation): the transaction still completes and the ack is still issued.
- Reset, including mid-transaction:
  - State returns to IDLE.
  - All outputs go to 0; no ack is issued for the aborted access.
  - The round-robin pointer is set to 1.

## Timing
- A req sampled in IDLE at cycle N gives:
  - Write: `ram_wr_o` at N+1, ack at N+2, IDLE at N+3.
  - Read: `ram_rd_o` at N+1, data captured at N+2, ack and data at N+3, IDLE at N+4.
- Throughput per port: one write per 3 cycles, one read per 4 cycles.
- All `ram_*`, ack and data outputs come directly from registers.

## Configuration
- `CHEBY_ARB_RR_EN` defined: round-robin arbitration.
  - When both reqs are 1 in IDLE, grant the port that is not `last`.
  - `last` is updated on every grant and resets to 1, so port 0 wins the first contention.
  - A lone requester is always granted immediately.
- `CHEBY_ARB_RR_EN` undefined: fixed priority. Port 0 always wins contention and the `last` register is not implemented.

## Test plan
- Single write: r0 writes adr=0x005, dat=0xA5, sel=1 → `ram_wr_o` one pulse at N+1 with adr=0x005, dat=0xA5; `r0_ack_o` at N+2; `r1_ack_o` stays 0.
- Read-back: r1 reads adr=0x005 while the RAM model returns 0xA5 one cycle after rd → `ram_rd_o` at N+1; `r1_ack_o`=1 with `r1_dat_o`=0xA5 at N+3.
- Contention, RR build:
  - Both ports request writes continuously from reset.
  - Required grant order: 0,1,0,1.
  - Acks spaced 3 cycles apart, never coincident.
- Contention, fixed-priority build: same stimulus with r0 re-requesting immediately after each ack → r0 is granted every time and r1 is acked only after r0 drops req.
- Stale req: requester keeps req=1 for one cycle after ack → no second `ram_wr_o` or `ram_rd_o` pulse and no second ack.
- Reset mid-read: assert `areset_n`=0 during RD → all outputs 0 immediately with no ack; after release, a new r0 write completes with ack at N+2.
